// File: rtl/serial_120_bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_120_bit_subtractor
// Description : Multi-cycle unsigned subtract, diff = a - b - borrow_in, one
//               CHUNK-bit slice per clock, LSB first, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_120_bit_subtractor #(
  parameter int WIDTH = 120,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int c_nchunk = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int c_padw   = c_nchunk * CHUNK;
  localparam int c_cntw   = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam logic [c_cntw-1:0] c_last = c_cntw'(c_nchunk - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [c_padw-1:0] r_a;
  logic [c_padw-1:0] r_b;
  logic              r_borrow;
  logic [c_cntw-1:0] r_cnt;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow_out;
  logic [CHUNK:0]    w_slice;

  assign w_last = (r_cnt == c_last);

  // Operands are zero-padded, so the reduced last slice still yields its
  // borrow in bit CHUNK of the (CHUNK+1)-bit difference.
  assign w_slice = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]}
                 - {{CHUNK{1'b0}}, r_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else if (w_load) begin
      r_a      <= c_padw'(a);
      r_b      <= c_padw'(b);
      r_borrow <= borrow_in;
      r_cnt    <= '0;
    end else if (w_step) begin
      // Operands shift down so the active slice always sits at bit 0.
      r_a      <= r_a >> CHUNK;
      r_b      <= r_b >> CHUNK;
      r_borrow <= w_slice[CHUNK];
      r_cnt    <= r_cnt + c_cntw'(1);
      for (int i = 0; i < WIDTH; i++) begin
        if ((i / CHUNK) == int'(r_cnt)) begin
          r_diff[i] <= w_slice[i % CHUNK];
        end
      end
      if (w_last) begin
        r_borrow_out <= w_slice[CHUNK];
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_120_bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_120_bit_subtractor
// Description : Directed and random checks of the serial subtractor against
//               a full-width arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_120_bit_subtractor;

  localparam int c_w = 120;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [c_w-1:0] a;
  logic [c_w-1:0] b;
  logic           borrow_in;
  logic           out_valid;
  logic           out_ready;
  logic [c_w-1:0] diff;
  logic           borrow_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_120_bit_subtractor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [c_w:0] model(input logic [c_w-1:0] ma, input logic [c_w-1:0] mb,
                                         input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - (c_w+1)'(mbin);
  endfunction

  function automatic logic [c_w-1:0] rnd120();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[c_w-1:0];
  endfunction

  // One complete operation: issue, wait for result, hold off the consumer for
  // 'hold' cycles while poking in_valid, then consume and check.
  task automatic do_op(input logic [c_w-1:0] ta, input logic [c_w-1:0] tb_v,
                       input logic tbin, input int hold);
    logic [c_w:0] exp;
    int cyc;
    exp = model(ta, tb_v, tbin);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    a = ta; b = tb_v; borrow_in = tbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = rnd120(); b = rnd120(); borrow_in = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_timeout", {127'd0, out_valid}, 128'd1);
    if (!out_valid) return;
    chk("latency", 128'(cyc), 128'd9);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      a = rnd120(); b = rnd120();
      @(negedge clk);
      chk("hold_out_valid", {127'd0, out_valid}, 128'd1);
      chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
      chk("hold_result", {7'd0, borrow_out, diff}, {7'd0, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("diff", {8'd0, diff}, {8'd0, exp[c_w-1:0]});
    chk("borrow_out", {127'd0, borrow_out}, {127'd0, exp[c_w]});
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    logic [c_w-1:0] ra;
    logic [c_w-1:0] rb;
    logic [c_w-1:0] ones;
    int sel;
    ones = '1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_diff", {8'd0, diff}, 128'd0);
    chk("rst_borrow_out", {127'd0, borrow_out}, 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(120'd5, 120'd3, 1'b0, 0);
    do_op(120'd0, 120'd1, 1'b0, 0);
    do_op(120'd1 << 16, 120'd1, 1'b0, 1);
    do_op(120'd1 << 119, 120'd1 << 119, 1'b1, 0);
    do_op(rnd120(), rnd120(), 1'b0, 5);

    // Abort in RUN cycle 4
    a = rnd120(); b = rnd120(); borrow_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_diff", {8'd0, diff}, 128'd0);
    chk("abort_borrow_out", {127'd0, borrow_out}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_result", {127'd0, out_valid}, 128'd0);
    end
    do_op(120'd100, 120'd200, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      sel = int'($urandom_range(0, 9));
      ra = rnd120();
      rb = rnd120();
      if (sel == 0) rb = ra;
      else if (sel == 1) begin ra = ones; rb = ones; end
      else if (sel == 2) ra = '0;
      else if (sel == 3) rb = ones;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
